// File: rtl/version_store_if.sv
// Write, read and response handshake bundle for the version store.
// Master drives requests and rspReady; slave returns readies and responses.
interface version_store_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int VERSION_WIDTH = 4
);
  logic                     wrValid;
  logic                     wrReady;
  logic [VERSION_WIDTH-1:0] wrVersion;
  logic [DATA_WIDTH-1:0]    wrData;
  logic                     wrDrop;
  logic                     rdValid;
  logic                     rdReady;
  logic [VERSION_WIDTH-1:0] rdVersion;
  logic                     rspValid;
  logic                     rspReady;
  logic                     rspHit;
  logic [VERSION_WIDTH-1:0] rspVersion;
  logic [DATA_WIDTH-1:0]    rspData;

  modport master (
    output wrValid, wrVersion, wrData,
    output rdValid, rdVersion, rspReady,
    input  wrReady, wrDrop, rdReady,
    input  rspValid, rspHit, rspVersion, rspData
  );

  modport slave (
    input  wrValid, wrVersion, wrData,
    input  rdValid, rdVersion, rspReady,
    output wrReady, wrDrop, rdReady,
    output rspValid, rspHit, rspVersion, rspData
  );
endinterface

// File: rtl/version_store.sv
// Small versioned store: unique-tag slots, oldest-tag eviction, and
// "newest entry strictly older than bound" lookups with a 1-cycle response.
module version_store #(
  parameter int DATA_WIDTH    = 32,
  parameter int VERSION_WIDTH = 4,
  parameter int VERSION_NUM   = 4
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         flush,
  version_store_if.slave               bus,
  output logic [$clog2(VERSION_NUM):0] occupancy
);
  localparam int N  = VERSION_NUM;
  localparam int IW = $clog2(VERSION_NUM);
  localparam int OW = IW + 1;

  typedef enum logic {IDLE, RESP} state_t;

  logic [N-1:0]             valid;
  logic [VERSION_WIDTH-1:0] tag  [N];
  logic [DATA_WIDTH-1:0]    data [N];

  logic                     hit_m, free_m, min_f, evict;
  logic [IW-1:0]            hit_i, free_i, min_i, wr_i;
  logic [VERSION_WIDTH-1:0] min_t;
  logic                     wr_fire, wr_go;

  logic                     lk_f;
  logic [IW-1:0]            lk_i;
  logic [VERSION_WIDTH-1:0] lk_t;

  state_t                   state, state_nx;
  logic                     rd_fire;

  assign bus.wrReady = ~flush;
  assign wr_fire     = bus.wrValid & ~flush;

  always_comb begin
    hit_m  = 1'b0;
    hit_i  = '0;
    free_m = 1'b0;
    free_i = '0;
    min_f  = 1'b0;
    min_i  = '0;
    min_t  = '0;
    for (int i = 0; i < N; i++) begin
      if (valid[i] && tag[i] == bus.wrVersion) begin
        hit_m = 1'b1;
        hit_i = IW'(i);
      end
      if (valid[i] && (!min_f || tag[i] < min_t)) begin
        min_f = 1'b1;
        min_i = IW'(i);
        min_t = tag[i];
      end
    end
    // descending scan leaves the lowest free index
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_m = 1'b1;
        free_i = IW'(i);
      end
    end
  end

  assign evict = min_f & (bus.wrVersion > min_t);

  always_comb begin
    wr_i = '0;
    if (hit_m)       wr_i = hit_i;
    else if (free_m) wr_i = free_i;
    else if (evict)  wr_i = min_i;
  end

  assign wr_go = wr_fire & (hit_m | free_m | evict);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      valid      <= '0;
      bus.wrDrop <= 1'b0;
    end else begin
      bus.wrDrop <= wr_fire & ~wr_go;
      if (flush)      valid       <= '0;
      else if (wr_go) valid[wr_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go) begin
      tag[wr_i]  <= bus.wrVersion;
      data[wr_i] <= bus.wrData;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < N; i++)
      occupancy = occupancy + OW'(valid[i]);
  end

  always_comb begin
    lk_f = 1'b0;
    lk_i = '0;
    lk_t = '0;
    for (int i = 0; i < N; i++) begin
      if (valid[i] && tag[i] < bus.rdVersion &&
          (!lk_f || tag[i] > lk_t)) begin
        lk_f = 1'b1;
        lk_i = IW'(i);
        lk_t = tag[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.rdValid) state_nx = RESP;
      RESP: if (bus.rspReady && !bus.rdValid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.rspValid = (state == RESP);
    bus.rdReady  = (state == IDLE) | bus.rspReady;
  end

  assign rd_fire = bus.rdValid & bus.rdReady;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      bus.rspHit     <= 1'b0;
      bus.rspVersion <= '0;
      bus.rspData    <= '0;
    end else if (rd_fire) begin
      bus.rspHit     <= lk_f;
      bus.rspVersion <= lk_f ? tag[lk_i] : '0;
      bus.rspData    <= lk_f ? data[lk_i] : '0;
    end
  end
endmodule

// File: tb/tb_version_store.sv
// Directed and random checks of version_store against a
// slot-array reference model built from the store's rules.
module tb_version_store;
  localparam int DW = 32;
  localparam int VW = 4;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic flush = 1'b0;
  logic [$clog2(N):0] occupancy;

  version_store_if #(.DATA_WIDTH(DW), .VERSION_WIDTH(VW)) bus ();

  version_store #(
    .DATA_WIDTH(DW), .VERSION_WIDTH(VW), .VERSION_NUM(N)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .flush(flush),
    .bus(bus.slave),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          m_valid [N];
  logic [VW-1:0] m_tag [N];
  logic [DW-1:0] m_data [N];
  bit          e_rv, e_hit, e_drop;
  logic [VW-1:0] e_ver;
  logic [DW-1:0] e_data;

  task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int m_occ();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_valid[i]);
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_valid[i] = 0;
    e_rv = 0; e_hit = 0; e_drop = 0; e_ver = '0; e_data = '0;
  endtask

  task automatic cyc(bit fl, bit wv, logic [VW-1:0] wver,
                     logic [DW-1:0] wd, bit rv,
                     logic [VW-1:0] rver, bit rr);
    int best;
    int slot;
    int mn;
    bit rd_acc;
    flush = fl;
    bus.wrValid = wv; bus.wrVersion = wver; bus.wrData = wd;
    bus.rdValid = rv; bus.rdVersion = rver; bus.rspReady = rr;
    #1;
    chk("wrReady", bus.wrReady, !fl);
    chk("rdReady", bus.rdReady, !e_rv || rr);
    rd_acc = rv && (!e_rv || rr);
    best = -1;
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_tag[i] < rver &&
          (best < 0 || m_tag[i] > m_tag[best])) best = i;
    if (rd_acc) begin
      e_rv   = 1;
      e_hit  = best >= 0;
      e_ver  = (best >= 0) ? m_tag[best] : '0;
      e_data = (best >= 0) ? m_data[best] : '0;
    end else if (e_rv && rr) begin
      e_rv = 0;
    end
    e_drop = 0;
    if (wv && !fl) begin
      slot = -1;
      for (int i = 0; i < N; i++)
        if (m_valid[i] && m_tag[i] == wver) slot = i;
      if (slot < 0)
        for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
      if (slot < 0) begin
        mn = 0;
        for (int i = 1; i < N; i++) if (m_tag[i] < m_tag[mn]) mn = i;
        if (wver > m_tag[mn]) slot = mn;
      end
      if (slot < 0) e_drop = 1;
      else begin
        m_valid[slot] = 1; m_tag[slot] = wver; m_data[slot] = wd;
      end
    end
    if (fl) for (int i = 0; i < N; i++) m_valid[i] = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rspValid", bus.rspValid, e_rv);
    chk("rspHit", bus.rspHit, e_hit);
    chk("rspVersion", bus.rspVersion, e_ver);
    chk("rspData", bus.rspData, e_data);
    chk("wrDrop", bus.wrDrop, e_drop);
    chk("occupancy", occupancy, m_occ());
  endtask

  task automatic idle();
    cyc(0, 0, '0, '0, 0, '0, 1);
  endtask

  initial begin
    bit fl, wv, rv, rr;
    bus.wrValid = 0; bus.wrVersion = '0; bus.wrData = '0;
    bus.rdValid = 0; bus.rdVersion = '0; bus.rspReady = 0;
    for (int i = 0; i < N; i++) begin
      m_tag[i] = '0; m_data[i] = '0;
    end
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_rspValid", bus.rspValid, 0);
    chk("rst_rspHit", bus.rspHit, 0);
    chk("rst_rspVersion", bus.rspVersion, 0);
    chk("rst_rspData", bus.rspData, 0);
    chk("rst_wrDrop", bus.wrDrop, 0);
    chk("rst_occupancy", occupancy, 0);
    rstN = 1'b1;
    @(negedge clk);

    cyc(0, 1, 4'd1, 32'hAAAA_0001, 0, '0, 1);
    cyc(0, 1, 4'd3, 32'hBBBB_0003, 0, '0, 1);
    cyc(0, 1, 4'd5, 32'hCCCC_0005, 0, '0, 1);
    cyc(0, 0, '0, '0, 1, 4'd4, 0);
    chk("r4_hit", bus.rspHit, 1);
    chk("r4_ver", bus.rspVersion, 3);
    chk("r4_data", bus.rspData, 32'hBBBB_0003);
    cyc(0, 0, '0, '0, 1, 4'd1, 1);
    chk("r1_hit", bus.rspHit, 0);
    chk("r1_data", bus.rspData, 0);
    cyc(0, 0, '0, '0, 1, 4'd15, 1);
    chk("r15_ver", bus.rspVersion, 5);
    chk("r15_data", bus.rspData, 32'hCCCC_0005);
    cyc(0, 0, '0, '0, 1, 4'd0, 1);
    chk("r0_hit", bus.rspHit, 0);
    idle();

    cyc(1, 0, '0, '0, 0, '0, 1);
    for (int t = 2; t <= 8; t += 2)
      cyc(0, 1, VW'(t), 32'h2000 + t, 0, '0, 1);
    cyc(0, 1, 4'd9, 32'h9999, 0, '0, 1);
    chk("evict_occ", occupancy, 4);
    cyc(0, 0, '0, '0, 1, 4'd3, 1);
    chk("evict_miss2", bus.rspHit, 0);
    cyc(0, 1, 4'd1, 32'h1111, 1, 4'd15, 1);
    chk("drop_pulse", bus.wrDrop, 1);
    chk("r15_after_evict", bus.rspVersion, 9);
    cyc(0, 1, 4'd6, 32'h6666, 0, '0, 1);
    chk("overwrite_drop", bus.wrDrop, 0);
    chk("overwrite_occ", occupancy, 4);
    idle();

    cyc(0, 0, '0, '0, 1, 4'd7, 0);
    repeat (3) begin
      cyc(0, 0, '0, '0, 1, 4'd10, 0);
      chk("hold_ver", bus.rspVersion, 6);
      chk("hold_data", bus.rspData, 32'h6666);
    end
    cyc(0, 0, '0, '0, 1, 4'd10, 1);
    chk("b2b_ver9", bus.rspVersion, 9);
    cyc(0, 0, '0, '0, 1, 4'd5, 1);
    chk("b2b_ver4", bus.rspVersion, 4);
    idle();

    cyc(0, 0, '0, '0, 1, 4'd15, 0);
    cyc(1, 0, '0, '0, 0, '0, 0);
    chk("flush_rspValid", bus.rspValid, 1);
    chk("flush_ver", bus.rspVersion, 9);
    chk("flush_occ", occupancy, 0);
    idle();

    cyc(0, 1, 4'd7, 32'h7777, 1, 4'd8, 1);
    chk("same_cyc_miss", bus.rspHit, 0);
    cyc(0, 0, '0, '0, 1, 4'd8, 1);
    chk("repeat_hit", bus.rspHit, 1);
    chk("repeat_ver", bus.rspVersion, 7);

    cyc(0, 0, '0, '0, 1, 4'd8, 0);
    bus.rdValid = 0;
    rstN = 1'b0;
    #1;
    chk("rst_mid_rspValid", bus.rspValid, 0);
    chk("rst_mid_occ", occupancy, 0);
    m_reset();
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    repeat (600) begin
      fl = ($urandom_range(0, 24) == 0);
      wv = ($urandom_range(0, 2) != 0);
      rv = ($urandom_range(0, 1) != 0);
      rr = ($urandom_range(0, 3) != 0);
      cyc(fl, wv, VW'($urandom_range(0, 15)), $urandom,
          rv, VW'($urandom_range(0, 15)), rr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
